// File: rtl/tcp_tx_scheduler.sv
// rtl/tcp_tx_scheduler.sv - round-robin framing scheduler of N_SRC sources onto the SiTCP TX byte stream
// Each frame is a 4-byte header (sync, id, len hi, len lo) followed by len payload bytes.
module tcp_tx_scheduler #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TCP_OPEN_ACK,
  input  logic                 FIFO_FULL,
  input  logic [N_SRC-1:0]     SRC_REQ,
  input  logic [16*N_SRC-1:0]  SRC_LEN,
  input  logic [8*N_SRC-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]     SRC_RD,
  output logic [N_SRC-1:0]     SRC_DONE,
  output logic [N_SRC-1:0]     SRC_ABORT,
  output logic [7:0]           TX_DATA,
  output logic                 TX_EN,
  output logic                 BUSY,
  output logic [2:0]           GRANT_ID,
  output logic [15:0]          FRAME_CNT
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [1:0]  hdr_idx;
  logic [15:0] len;
  logic [15:0] byte_cnt;

  logic             found;
  logic [2:0]       pick;
  logic [15:0]      pick_len;
  logic [N_SRC-1:0] grant_oh;
  logic [7:0]       cur_data;
  logic [7:0]       hdr_byte;
  logic             rd_en;

  // First requester strictly after the last winner, wrapping modulo N_SRC.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 1; i <= N_SRC; i++) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (!found && SRC_REQ[j] && (j == (int'(ptr) + i) % N_SRC)) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  always_comb begin
    pick_len = '0;
    cur_data = '0;
    grant_oh = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (pick == 3'(j))
        pick_len = SRC_LEN[16*j +: 16];
      if (GRANT_ID == 3'(j)) begin
        cur_data    = SRC_DATA[8*j +: 8];
        grant_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    hdr_byte = len[7:0];
    case (hdr_idx)
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = {5'b0, GRANT_ID};
      2'd2:    hdr_byte = len[15:8];
      default: hdr_byte = len[7:0];
    endcase
  end

  assign rd_en  = (state == DATA) && !FIFO_FULL && TCP_OPEN_ACK;
  assign SRC_RD = rd_en ? grant_oh : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= 3'(N_SRC - 1);
      hdr_idx   <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      SRC_DONE  <= '0;
      SRC_ABORT <= '0;
      TX_DATA   <= '0;
      TX_EN     <= 1'b0;
      BUSY      <= 1'b0;
      GRANT_ID  <= '0;
      FRAME_CNT <= '0;
    end else begin
      TX_EN     <= 1'b0;
      SRC_DONE  <= '0;
      SRC_ABORT <= '0;
      case (state)
        IDLE: begin
          if (TCP_OPEN_ACK && found) begin
            GRANT_ID <= pick;
            ptr      <= pick;
            len      <= pick_len;
            BUSY     <= 1'b1;
            hdr_idx  <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (!TCP_OPEN_ACK) begin
            SRC_ABORT <= grant_oh;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else if (!FIFO_FULL) begin
            TX_DATA <= hdr_byte;
            TX_EN   <= 1'b1;
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              byte_cnt <= '0;
              state    <= (len == 16'd0) ? DONE : DATA;
            end
          end
        end
        DATA: begin
          if (!TCP_OPEN_ACK) begin
            SRC_ABORT <= grant_oh;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else if (rd_en) begin
            TX_DATA  <= cur_data;
            TX_EN    <= 1'b1;
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == len - 16'd1)
              state <= DONE;
          end
        end
        DONE: begin
          SRC_DONE  <= grant_oh;
          FRAME_CNT <= FRAME_CNT + 16'd1;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tcp_tx_scheduler.md
Name: tcp_tx_scheduler

Overview:
- Shares the single SiTCP transmit byte stream (TCP_TX_DATA_IN/TCP_TX_EN_IN into the TX FIFO) among N_SRC data sources.
- Arbitrates round-robin at frame granularity and prefixes each frame with a 4-byte header (sync, source id, length).
- Paces output on the FIFO almost-full flag and stops cleanly when the TCP connection drops.
- Sits between the detector readout sources and the SiTCP wrapper, in the CLK_200M domain.

Parameters:
N_SRC, 4, number of requesters (2..8)
SYNC_BYTE, 8'hA5, first header byte

Ports:
CLK  in  1  system clock (CLK_200M)
RST  in  1  synchronous, active-high reset
TCP_OPEN_ACK  in  1  SiTCP connection open
FIFO_FULL  in  1  TX FIFO almost-full
SRC_REQ  in  N_SRC  per-source frame request, level
SRC_LEN  in  16*N_SRC  per-source payload byte count, stable while SRC_REQ=1
SRC_DATA  in  8*N_SRC  per-source first-word-fall-through byte
SRC_RD  out  N_SRC  per-source byte-consume strobe, combinational
SRC_DONE  out  N_SRC  one-cycle pulse when a frame completes
SRC_ABORT  out  N_SRC  one-cycle pulse when a frame is aborted
TX_DATA  out  8  byte to FIFO din (registered)
TX_EN  out  1  FIFO wr_en (registered)
BUSY  out  1  frame in progress
GRANT_ID  out  3  current or last granted source
FRAME_CNT  out  16  completed frames, wraps 16'hFFFF->0

Behaviour:
- Reset values: all outputs 0.
  - Round-robin pointer = N_SRC-1, so source 0 wins first.
  - State IDLE.
  - RST takes priority over everything, including mid-frame.
  - No SRC_DONE or SRC_ABORT pulse on reset.
- States: IDLE, HDR, DATA, DONE.
- IDLE:
  - If TCP_OPEN_ACK=1 and SRC_REQ!=0, grant the first set request searching from pointer+1 (mod N_SRC).
  - Latch GRANT_ID and SRC_LEN[g], set BUSY=1, clear hdr_idx, go to HDR.
  - Pointer is updated to g on grant.
- HDR: four bytes, in order:
  - SYNC_BYTE
  - {5'b0, g}
  - LEN[15:8]
  - LEN[7:0]
  - One byte is emitted per cycle in which FIFO_FULL=0. On the 4th byte: if LEN=0 go to DONE, else go to DATA with byte_cnt=0.
- DATA:
  - SRC_RD[g] = (state==DATA) & ~FIFO_FULL & TCP_OPEN_ACK. All other SRC_RD bits are 0.
  - On a cycle with SRC_RD[g]=1: TX_DATA<=SRC_DATA[g], TX_EN<=1, byte_cnt++.
  - When byte_cnt reaches LEN-1 with SRC_RD[g]=1, go to DONE.
  - The source must present the next byte the cycle after SRC_RD. REQ is only raised when the whole frame is buffered, so no data underflow exists.
- DONE (one cycle):
  - SRC_DONE[g]=1, FRAME_CNT++, BUSY<=0, go to IDLE.
  - This gives a minimum of 2 idle cycles between frames. Arbitration happens in IDLE.
- Emission timing: TX_EN is 1 exactly in the cycle after an emitting cycle. It is 0 in every cycle following a FIFO_FULL=1 cycle (latency 1).
- Abort: TCP_OPEN_ACK=0 while in HDR or DATA.
  - No byte emitted that cycle.
  - Next cycle: SRC_ABORT[g]=1, BUSY=0, state IDLE, FRAME_CNT unchanged.
  - The source discards the remainder itself.
- SRC_REQ deassertion by the granted source mid-frame is ignored; the frame runs to completion or abort.
- Simultaneous requests are served strictly round-robin; a continuously requesting source cannot starve the others.
- byte_cnt and LEN are 16-bit. LEN=16'hFFFF is legal and yields 65535 payload bytes.

Test Plan:
- Single source: SRC_REQ[0]=1, LEN=3, data 11,22,33, FIFO_FULL=0 -> TX bytes A5,00,00,03,11,22,33 on 7 consecutive TX_EN cycles; SRC_DONE[0] pulse once; FRAME_CNT=1.
- Fairness: REQ[0], REQ[2] and REQ[3] held high, each LEN=2 -> frames granted in order 0,2,3,0,2,3; GRANT_ID matches each header's id byte.
- Backpressure: LEN=4, FIFO_FULL high for 5 cycles mid-DATA -> TX_EN=0 during the stall (delayed by 1); no byte lost or duplicated; SRC_RD count=4.
- Zero length: LEN=0 -> header A5,id,00,00 only; SRC_RD never asserted; SRC_DONE pulse.
- Abort: TCP_OPEN_ACK drops after 2 payload bytes of a LEN=10 frame -> no further TX_EN; SRC_ABORT[g] pulse; FRAME_CNT unchanged; next frame waits for TCP_OPEN_ACK=1.
- Reset mid-frame: RST during DATA -> all outputs 0 next cycle; no DONE or ABORT pulse; next grant goes to source 0.
